// File: rtl/accel_spi_if.sv
// Pin bundle between the accelerometer SPI responder and its environment:
// SPI pins, sample input port and status outputs.
interface accel_spi_if;
  logic        CS;
  logic        SCLK;
  logic        DIN;
  logic        DO;
  logic        DO_OE;
  logic        SAMPLE_VALID;
  logic [15:0] OUT_X;
  logic [15:0] OUT_Y;
  logic [15:0] OUT_Z;
  logic        INT1;
  logic [7:0]  CTRL_REG1;
  logic        BUSY;

  modport slave (
    input  CS, SCLK, DIN, SAMPLE_VALID,
    input  OUT_X, OUT_Y, OUT_Z,
    output DO, DO_OE, INT1, CTRL_REG1, BUSY
  );

  modport master (
    output CS, SCLK, DIN, SAMPLE_VALID,
    output OUT_X, OUT_Y, OUT_Z,
    input  DO, DO_OE, INT1, CTRL_REG1, BUSY
  );
endinterface

// File: rtl/accel_spi_responder.sv
// SPI mode-3 register responder for a 3-axis accelerometer, oversampled
// on SYS_CLK, with a one-entry sample buffer held off during transactions.
module accel_spi_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
  parameter logic [7:0] CTRL1_RST    = 8'h07
) (
  input logic        SYS_CLK,
  input logic        RESET_N,
  accel_spi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, nxt;

  logic [1:0] cs_s, sclk_s, din_s;
  logic       cs_d, sclk_d;
  logic       cs_q, cs_fall, sclk_rise, sclk_fall;

  logic [2:0] bit_cnt;
  logic [7:0] shift_in, shift_out, byte_in;
  logic [5:0] addr, addr_nxt;
  logic       rw, ms, do_r;
  logic [7:0] ctrl1;

  logic [15:0] x_r, y_r, z_r;
  logic [15:0] px, py, pz;
  logic        pend_v, busy, busy_d;
  logic        zda, zor;
  logic        byte_done, clr_evt;
  logic        live, from_pend;

  // CS sync resets low so a CS held low across reset never looks like a
  // fresh falling edge; the transaction restarts only on a real one.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_s   <= 2'b00;
      cs_d   <= 1'b0;
      sclk_s <= 2'b11;
      sclk_d <= 1'b1;
      din_s  <= 2'b00;
    end else begin
      cs_s   <= {cs_s[0], bus.CS};
      cs_d   <= cs_s[1];
      sclk_s <= {sclk_s[0], bus.SCLK};
      sclk_d <= sclk_s[1];
      din_s  <= {din_s[0], bus.DIN};
    end
  end

  assign cs_q      = cs_s[1];
  assign cs_fall   = cs_d & ~cs_q;
  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = sclk_d & ~sclk_s[1];
  assign byte_in   = {shift_in[6:0], din_s[1]};
  assign addr_nxt  = ms ? addr + 6'd1 : addr;
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_q;

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (cs_q) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) nxt = CMD;
        CMD:     if (byte_done) nxt = DATA;
        default: nxt = state;
      endcase
    end
  end

  function automatic logic [7:0] rd(input logic [5:0] a);
    case (a)
      6'h0F:   rd = WHO_AM_I_VAL;
      6'h20:   rd = ctrl1;
      6'h27:   rd = {zor, 3'b000, zda, 3'b000};
      6'h28:   rd = x_r[7:0];
      6'h29:   rd = x_r[15:8];
      6'h2A:   rd = y_r[7:0];
      6'h2B:   rd = y_r[15:8];
      6'h2C:   rd = z_r[7:0];
      6'h2D:   rd = z_r[15:8];
      default: rd = 8'h00;
    endcase
  endfunction

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt   <= 3'd0;
      shift_in  <= 8'h00;
      shift_out <= 8'h00;
      addr      <= 6'h00;
      rw        <= 1'b0;
      ms        <= 1'b0;
      do_r      <= 1'b0;
      ctrl1     <= CTRL1_RST;
    end else if (state == IDLE || cs_q) begin
      bit_cnt <= 3'd0;
      do_r    <= 1'b0;
    end else begin
      if (sclk_rise) begin
        shift_in <= byte_in;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (state == CMD) begin
            rw        <= byte_in[7];
            ms        <= byte_in[6];
            addr      <= byte_in[5:0];
            shift_out <= rd(byte_in[5:0]);
          end else begin
            addr <= addr_nxt;
            if (rw) shift_out <= rd(addr_nxt);
            else if (addr == 6'h20) ctrl1 <= byte_in;
          end
        end
      end
      if (sclk_fall && state == DATA && rw) begin
        do_r      <= shift_out[7];
        shift_out <= {shift_out[6:0], 1'b0};
      end
    end
  end

  assign busy      = (state != IDLE);
  assign clr_evt   = byte_done && (state == DATA) && rw && (addr == 6'h2D);
  assign live      = bus.SAMPLE_VALID && !busy;
  assign from_pend = !live && busy_d && !busy && pend_v;

  // A live sample while idle always wins over a stale pending one.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_r    <= 16'h0000;
      y_r    <= 16'h0000;
      z_r    <= 16'h0000;
      px     <= 16'h0000;
      py     <= 16'h0000;
      pz     <= 16'h0000;
      pend_v <= 1'b0;
      busy_d <= 1'b0;
      zda    <= 1'b0;
      zor    <= 1'b0;
    end else begin
      busy_d <= busy;
      if (bus.SAMPLE_VALID && busy) begin
        px     <= bus.OUT_X;
        py     <= bus.OUT_Y;
        pz     <= bus.OUT_Z;
        pend_v <= 1'b1;
      end else if (live || from_pend) begin
        pend_v <= 1'b0;
      end
      if (live) begin
        x_r <= bus.OUT_X;
        y_r <= bus.OUT_Y;
        z_r <= bus.OUT_Z;
      end else if (from_pend) begin
        x_r <= px;
        y_r <= py;
        z_r <= pz;
      end
      if (live || from_pend) begin
        zda <= 1'b1;
        zor <= zor | zda;
      end else if (clr_evt) begin
        zda <= 1'b0;
        zor <= 1'b0;
      end
    end
  end

  assign bus.DO        = do_r;
  assign bus.DO_OE     = busy;
  assign bus.BUSY      = busy;
  assign bus.INT1      = zda;
  assign bus.CTRL_REG1 = ctrl1;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: SPI mode-3 master driving
// register reads/writes, sample buffering, aborts and reset.
module tb_accel_spi_responder;

  logic SYS_CLK;
  logic RESET_N;
  int   vectors;
  int   miscompares;
  logic [7:0] rx;

  accel_spi_if bus ();

  accel_spi_responder #(
    .WHO_AM_I_VAL(8'h33),
    .CTRL1_RST   (8'h07)
  ) dut (
    .SYS_CLK(SYS_CLK),
    .RESET_N(RESET_N),
    .bus    (bus.slave)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      bus.SCLK = 1'b0;
      bus.DIN  = tx[i];
      #80;
      bus.SCLK = 1'b1;
      r[i]     = bus.DO;
      #80;
    end
  endtask

  task automatic cs_low();
    bus.CS = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #100;
    bus.CS = 1'b1;
    #100;
  endtask

  task automatic sample(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z);
    @(negedge SYS_CLK);
    bus.OUT_X        = x;
    bus.OUT_Y        = y;
    bus.OUT_Z        = z;
    bus.SAMPLE_VALID = 1'b1;
    @(negedge SYS_CLK);
    bus.SAMPLE_VALID = 1'b0;
    #20;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    RESET_N          = 1'b0;
    bus.CS           = 1'b1;
    bus.SCLK         = 1'b1;
    bus.DIN          = 1'b0;
    bus.SAMPLE_VALID = 1'b0;
    bus.OUT_X        = 16'h0;
    bus.OUT_Y        = 16'h0;
    bus.OUT_Z        = 16'h0;
    #33;
    chk("rst_do", {15'h0, bus.DO}, 16'h0);
    chk("rst_oe", {15'h0, bus.DO_OE}, 16'h0);
    chk("rst_busy", {15'h0, bus.BUSY}, 16'h0);
    chk("rst_int1", {15'h0, bus.INT1}, 16'h0);
    chk("rst_ctrl", {8'h0, bus.CTRL_REG1}, 16'h0007);
    RESET_N = 1'b1;
    #50;

    // WHO_AM_I read
    cs_low();
    chk("oe_cs_low", {15'h0, bus.DO_OE}, 16'h1);
    chk("busy_cs_low", {15'h0, bus.BUSY}, 16'h1);
    spi_byte(8'h8F, rx);
    spi_byte(8'h00, rx);
    chk("who_am_i", {8'h0, rx}, 16'h0033);
    cs_high();
    chk("oe_cs_high", {15'h0, bus.DO_OE}, 16'h0);
    chk("do_cs_high", {15'h0, bus.DO}, 16'h0);

    // sample then burst read all axes
    sample(16'h1234, 16'hABCD, 16'h8001);
    chk("int1_set", {15'h0, bus.INT1}, 16'h1);
    cs_low();
    spi_byte(8'hE8, rx);
    spi_byte(8'h00, rx); chk("x_l", {8'h0, rx}, 16'h0034);
    spi_byte(8'h00, rx); chk("x_h", {8'h0, rx}, 16'h0012);
    spi_byte(8'h00, rx); chk("y_l", {8'h0, rx}, 16'h00CD);
    spi_byte(8'h00, rx); chk("y_h", {8'h0, rx}, 16'h00AB);
    spi_byte(8'h00, rx); chk("z_l", {8'h0, rx}, 16'h0001);
    chk("int1_before_zh", {15'h0, bus.INT1}, 16'h1);
    spi_byte(8'h00, rx); chk("z_h", {8'h0, rx}, 16'h0080);
    cs_high();
    chk("int1_cleared", {15'h0, bus.INT1}, 16'h0);

    // write CTRL_REG1, read back; write to read-only WHO_AM_I
    cs_low(); spi_byte(8'h20, rx); spi_byte(8'h57, rx); cs_high();
    chk("ctrl_port", {8'h0, bus.CTRL_REG1}, 16'h0057);
    cs_low(); spi_byte(8'hA0, rx); spi_byte(8'h00, rx); cs_high();
    chk("ctrl_read", {8'h0, rx}, 16'h0057);
    cs_low(); spi_byte(8'h0F, rx); spi_byte(8'h00, rx); cs_high();
    cs_low(); spi_byte(8'h8F, rx); spi_byte(8'h00, rx); cs_high();
    chk("who_am_i_ro", {8'h0, rx}, 16'h0033);

    // samples during a burst are deferred, newest wins, overrun flagged
    sample(16'h0A0B, 16'h0C0D, 16'h0E0F);
    cs_low();
    spi_byte(8'hE8, rx);
    spi_byte(8'h00, rx); chk("old_x_l", {8'h0, rx}, 16'h000B);
    sample(16'h1111, 16'h0000, 16'h0000);
    spi_byte(8'h00, rx); chk("old_x_h", {8'h0, rx}, 16'h000A);
    sample(16'h2222, 16'h0000, 16'h0000);
    spi_byte(8'h00, rx); chk("old_y_l", {8'h0, rx}, 16'h000D);
    cs_high();
    cs_low(); spi_byte(8'hA7, rx); spi_byte(8'h00, rx); cs_high();
    chk("status_ovr", {8'h0, rx}, 16'h0088);
    cs_low();
    spi_byte(8'hE8, rx);
    spi_byte(8'h00, rx); chk("new_x_l", {8'h0, rx}, 16'h0022);
    spi_byte(8'h00, rx); chk("new_x_h", {8'h0, rx}, 16'h0022);
    cs_high();

    // address wrap 0x3F -> 0x00
    cs_low();
    spi_byte(8'hFF, rx);
    spi_byte(8'h00, rx); chk("wrap_3f", {8'h0, rx}, 16'h0000);
    spi_byte(8'h00, rx); chk("wrap_00", {8'h0, rx}, 16'h0000);
    cs_high();

    // partial command abort: 5 bits of a CTRL_REG1 write
    cs_low();
    for (int i = 7; i >= 3; i--) begin
      bus.SCLK = 1'b0;
      bus.DIN  = (i == 5);
      #80;
      bus.SCLK = 1'b1;
      #80;
    end
    cs_high();
    chk("abort_busy", {15'h0, bus.BUSY}, 16'h0);
    cs_low(); spi_byte(8'h00, rx); cs_high();
    chk("abort_ctrl", {8'h0, bus.CTRL_REG1}, 16'h0057);

    // reset mid data byte of a read, then SCLK ignored until CS falls
    cs_low();
    spi_byte(8'hA0, rx);
    for (int i = 0; i < 3; i++) begin
      bus.SCLK = 1'b0; #80;
      bus.SCLK = 1'b1; #80;
    end
    RESET_N = 1'b0;
    #30;
    chk("rst_mid_busy", {15'h0, bus.BUSY}, 16'h0);
    chk("rst_mid_oe", {15'h0, bus.DO_OE}, 16'h0);
    chk("rst_mid_ctrl", {8'h0, bus.CTRL_REG1}, 16'h0007);
    RESET_N = 1'b1;
    #50;
    spi_byte(8'h20, rx);
    chk("post_rst_busy", {15'h0, bus.BUSY}, 16'h0);
    chk("post_rst_oe", {15'h0, bus.DO_OE}, 16'h0);
    chk("post_rst_ctrl", {8'h0, bus.CTRL_REG1}, 16'h0007);
    cs_high();
    sample(16'h0001, 16'h0002, 16'h0003);
    cs_low(); spi_byte(8'hA7, rx); spi_byte(8'h00, rx); cs_high();
    chk("status_after_rst", {8'h0, rx}, 16'h0008);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/accel_spi_responder.md
ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 SHALL have parameter WHO_AM_I_VAL, default 8'h33, value returned at address 0x0F.
REQ-002 SHALL have parameter CTRL1_RST, default 8'h07, reset value of CTRL_REG1.
REQ-003 SHALL have port SYS_CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CS  input  1  SPI chip select from master, active low, asynchronous to SYS_CLK.
REQ-006 SHALL have port SCLK  input  1  SPI clock, mode 3 (idle high), asynchronous.
REQ-007 SHALL have port DIN  input  1  master-to-responder serial data.
REQ-008 SHALL have port DO  output  1  responder-to-master serial data.
REQ-009 SHALL have port DO_OE  output  1  DO drive enable, 1 only while CS low.
REQ-010 SHALL have port SAMPLE_VALID  input  1  one-cycle strobe qualifying OUT_X/OUT_Y/OUT_Z.
REQ-011 SHALL have ports OUT_X, OUT_Y, OUT_Z  input  16 each  two's complement, left-justified sample.
REQ-012 SHALL have port INT1  output  1  data-ready interrupt, equals STATUS ZYXDA bit.
REQ-013 SHALL have port CTRL_REG1  output  8  current CTRL_REG1 contents.
REQ-014 SHALL have port BUSY  output  1  1 while a transaction is in progress (state not IDLE).

Function
REQ-015 SHALL pass CS, SCLK, DIN through 2-flop synchronizers; SYS_CLK >= 8x SCLK is required; SCLK edges detected from synchronized samples.
REQ-016 SHALL implement states IDLE, CMD, DATA; synchronized CS falling: IDLE->CMD; 8th SCLK rising in CMD: CMD->DATA; synchronized CS high: any state->IDLE within 1 cycle, bit counter cleared, partial byte discarded.
REQ-017 SHALL sample DIN on SCLK rising edges, MSB first; 3-bit bit counter wraps 7->0 per byte.
REQ-018 SHALL decode command byte: bit7 RW (1=read), bit6 MS (1=auto-increment), bits5:0 address.
REQ-019 SHALL, for reads, load the addressed register into the shift register on the 8th rising edge of each byte and drive bit7 on the following SCLK falling edge, subsequent bits on subsequent falling edges.
REQ-020 SHALL, for writes, commit the received byte to the addressed register on the 8th rising edge of each data byte.
REQ-021 SHALL, when MS=1, increment address after each data byte, wrapping 0x3F->0x00; when MS=0, keep address fixed.
REQ-022 SHALL implement map: 0x0F WHO_AM_I (RO), 0x20 CTRL_REG1 (RW), 0x27 STATUS (RO; bit3 ZYXDA, bit7 ZYXOR, others 0), 0x28..0x2D OUT_X_L, OUT_X_H, OUT_Y_L, OUT_Y_H, OUT_Z_L, OUT_Z_H (RO); all other addresses read 0x00; writes to RO/unmapped addresses ignored.
REQ-023 SHALL, on SAMPLE_VALID with BUSY=0, copy OUT_X/Y/Z into output registers that cycle.
REQ-024 SHALL, on SAMPLE_VALID with BUSY=1, hold the sample in a one-entry pending buffer (newer overwrites older) and commit it in the cycle BUSY falls; SAMPLE_VALID in that same cycle takes precedence.
REQ-025 SHALL set ZYXDA on each commit; SHALL set ZYXOR if ZYXDA already 1 at commit.
REQ-026 SHALL clear ZYXDA and ZYXOR when a read byte from 0x2D completes; simultaneous set and clear: set wins.
REQ-027 SHALL drive DO=0 and DO_OE=0 while CS (synchronized) high.

Reset
REQ-028 SHALL on RESET_N low: state IDLE, DO=0, DO_OE=0, BUSY=0, INT1=0, CTRL_REG1=CTRL1_RST, STATUS=0x00, output registers 0x00, pending buffer empty.
REQ-029 SHALL, on reset asserted mid-transaction, abort; after release, ignore SCLK until next CS falling edge.

Verification
REQ-030 Read 0x8F then 8 clocks -> DO shifts 0x33, DO_OE=1 during CS low, 0 after.
REQ-031 SAMPLE_VALID X=0x1234,Y=0xABCD,Z=0x8001, then read 0xE8 + 6 bytes -> 0x34,0x12,0xCD,0xAB,0x01,0x80; INT1 1 before, 0 after last byte.
REQ-032 Write 0x20 data 0x57 then read 0xA0 -> 0x57, CTRL_REG1=0x57; write 0x0F data 0x00 -> WHO_AM_I still 0x33.
REQ-033 SAMPLE_VALID X=0x1111 mid burst, second X=0x2222 before CS high -> burst returns old data, after CS high OUT_X=0x2222, ZYXOR=1.
REQ-034 CS high after 5 bits of command, then reset mid-byte of a second read -> no register change, state IDLE, DO_OE=0, next read 0xA7 returns correct STATUS.
REQ-035 Read 0xFF + 2 bytes -> address wraps to 0x00, both bytes 0x00.
